// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the forwarding/hazard logic: operand-mux select codes,
// scoreboard slot layout, and the producer-match helper.
package rv_pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RET   = 2'b11;

  // Slot index = how many instructions older than the ID instruction, minus one.
  localparam int SLOT_EX   = 0;
  localparam int SLOT_MEM  = 1;
  localparam int SLOT_WB   = 2;
  localparam int NUM_SLOTS = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } sb_slot_t;

  function automatic logic is_producer(input sb_slot_t slot, input logic [4:0] src);
    return slot.valid && slot.regwrite && (slot.rd == src) && (slot.rd != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding select and load-hit detection, youngest producer first.
// With FWD_RET_BYPASS_EN defined, a producer three instructions older selects the retired-value register.
module fwd_operand_sel
  import rv_pipe_pkg::*;
(
  input  logic                     [4:0] src,
  input  logic                           use_src,
  input  sb_slot_t [NUM_SLOTS-1:0]       slots,
  output logic                     [1:0] sel,
  output logic                           load_hit
);

  logic unused_memread_s;
  assign unused_memread_s = slots[SLOT_MEM].memread ^ slots[SLOT_WB].memread;

  // Priority select over the scoreboard; only the EX-slot load can still cause a hazard.
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (!use_src) begin
      sel = FWD_RF;
    end else if (is_producer(slots[SLOT_EX], src)) begin
      sel      = FWD_EXMEM;
      load_hit = slots[SLOT_EX].memread;
    end else if (is_producer(slots[SLOT_MEM], src)) begin
      sel = FWD_MEMWB;
`ifdef FWD_RET_BYPASS_EN
    end else if (is_producer(slots[SLOT_WB], src)) begin
      // RF write lands at the end of this cycle, too late for the ID read; bypass from the retired register.
      sel = FWD_RET;
`else
    end else if (is_producer(slots[SLOT_WB], src)) begin
      // Write-first register file already returns this value in ID.
      sel = FWD_RF;
`endif
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Optional retired-value bypass selected by defining FWD_RET_BYPASS_EN.
module fwd_hazard_ctrl
  import rv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       ex_flush,
  output logic       stall,
  output logic       ex_bubble,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  sb_slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
  logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0] fwd_b_sel_q, fwd_b_sel_d;
  logic       ex_bubble_q, ex_bubble_d;
  logic [1:0] sel_a_s, sel_b_s;
  logic       hit_a_s, hit_b_s;
  logic       issue_s;

  fwd_operand_sel u_sel_a (
    .src      (id_rs1),
    .use_src  (id_use_rs1),
    .slots    (slots_q),
    .sel      (sel_a_s),
    .load_hit (hit_a_s)
  );

  fwd_operand_sel u_sel_b (
    .src      (id_rs2),
    .use_src  (id_use_rs2),
    .slots    (slots_q),
    .sel      (sel_b_s),
    .load_hit (hit_b_s)
  );

  // Load-use stall; a taken branch squashes ID so it never stalls.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !ex_flush) begin
      stall = hit_a_s || hit_b_s;
    end else begin
      stall = 1'b0;
    end
  end

  assign issue_s = id_valid && !stall && !ex_flush;

  // Scoreboard advance and registered EX-stage controls.
  always_comb begin
    slots_d          = slots_q;
    slots_d[SLOT_WB] = slots_q[SLOT_MEM];
    slots_d[SLOT_MEM] = slots_q[SLOT_EX];
    fwd_a_sel_d      = FWD_RF;
    fwd_b_sel_d      = FWD_RF;
    ex_bubble_d      = 1'b1;
    if (issue_s) begin
      slots_d[SLOT_EX] = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      fwd_a_sel_d      = sel_a_s;
      fwd_b_sel_d      = sel_b_s;
      ex_bubble_d      = 1'b0;
    end else begin
      slots_d[SLOT_EX] = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= '0;
      fwd_a_sel_q <= FWD_RF;
      fwd_b_sel_q <= FWD_RF;
      ex_bubble_q <= 1'b1;
    end else begin
      slots_q     <= slots_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
      ex_bubble_q <= ex_bubble_d;
    end
  end

  assign ex_bubble = ex_bubble_q;
  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table plus random stimulus
// against an instruction-history model. Honors FWD_RET_BYPASS_EN for the distance-3 expectation.
module tb_fwd_hazard_ctrl;

`ifdef FWD_RET_BYPASS_EN
  localparam logic [1:0] DIST3_SEL = 2'b11;
`else
  localparam logic [1:0] DIST3_SEL = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
    .stall(stall), .ex_bubble(ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  typedef struct {
    logic       rst, valid;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic       e_stall;
    logic [1:0] e_a, e_b;
    logic       e_bub;
  } vec_t;

  // Issued-instruction history: index 0 is the one most recently sent to EX.
  typedef struct { logic valid; logic [4:0] rd; logic rw; logic mr; } instr_t;
  instr_t     hist [3];
  logic [1:0] m_a, m_b;
  logic       m_bub;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb, logic ebub);
    vec_t t;
    t.rst = r; t.valid = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.mr = mr; t.fl = fl;
    t.e_stall = es; t.e_a = ea; t.e_b = eb; t.e_bub = ebub;
    return t;
  endfunction

  function automatic logic [1:0] model_sel(logic [4:0] src, logic use_it);
    logic [1:0] code [3];
    code[0] = 2'b01; code[1] = 2'b10; code[2] = DIST3_SEL;
    if (!use_it || src == 5'd0) return 2'b00;
    for (int d = 0; d < 3; d++)
      if (hist[d].valid && hist[d].rw && hist[d].rd == src) return code[d];
    return 2'b00;
  endfunction

  function automatic logic model_stall(vec_t v);
    if (!v.valid || v.fl) return 1'b0;
    if (!(hist[0].valid && hist[0].rw && hist[0].mr && hist[0].rd != 5'd0)) return 1'b0;
    return (v.u1 && v.rs1 == hist[0].rd) || (v.u2 && v.rs2 == hist[0].rd);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input bit use_table, input string tag);
    logic       e_stall, ms, issue;
    logic [1:0] e_a, e_b;
    logic       e_bub;
    rst = v.rst; id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rd = v.rd;
    id_regwrite = v.rw; id_memread = v.mr; ex_flush = v.fl;
    #1;
    ms = model_stall(v);
    e_stall = use_table ? v.e_stall : ms;
    check({tag, ".stall"}, {1'b0, stall}, {1'b0, e_stall});
    issue = v.valid && !ms && !v.fl;
    if (v.rst) begin
      m_a = 2'b00; m_b = 2'b00; m_bub = 1'b1;
      for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
    end else begin
      m_a   = issue ? model_sel(v.rs1, v.u1) : 2'b00;
      m_b   = issue ? model_sel(v.rs2, v.u2) : 2'b00;
      m_bub = !issue;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = issue ? '{1'b1, v.rd, v.rw, v.mr} : '{1'b0, 5'd0, 1'b0, 1'b0};
    end
    e_a   = use_table ? v.e_a   : m_a;
    e_b   = use_table ? v.e_b   : m_b;
    e_bub = use_table ? v.e_bub : m_bub;
    @(posedge clk);
    #1;
    check({tag, ".fwd_a"}, fwd_a_sel, e_a);
    check({tag, ".fwd_b"}, fwd_b_sel, e_b);
    check({tag, ".bubble"}, {1'b0, ex_bubble}, {1'b0, e_bub});
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_a = 2'b00; m_b = 2'b00; m_bub = 1'b1;

    //           rst  v   rs1    rs2    u1   u2   rd     rw   mr   fl  | stall a      b      bub
    tbl.push_back(mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    tbl.push_back(mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    // add x5,x1,x2 ; add x6,x5,x3
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd5, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd5, 5'd3, 1'b1,1'b1,5'd6, 1'b1,1'b0,1'b0, 1'b0,2'b01,2'b00,1'b0));
    // add x5 ; add x9 ; sub x7,x4,x5 (distance 2)
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd5, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd9, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd4, 5'd5, 1'b1,1'b1,5'd7, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b10,1'b0));
    // add x5 ; add x9 ; add x10 ; sub x7,x4,x5 (distance 3)
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd5, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd9, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd10,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd4, 5'd5, 1'b1,1'b1,5'd7, 1'b1,1'b0,1'b0, 1'b0,2'b00,DIST3_SEL,1'b0));
    // lw x7,0(x1) ; add x8,x7,x7 stalls once, then reissues with MEM/WB forwarding
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd0, 1'b1,1'b0,5'd7, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd7, 5'd7, 1'b1,1'b1,5'd8, 1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b1));
    tbl.push_back(mk(1'b0,1'b1,5'd7, 5'd7, 1'b1,1'b1,5'd8, 1'b1,1'b0,1'b0, 1'b0,2'b10,2'b10,1'b0));
    // addi x0,x1,1 ; add x2,x0,x0
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd0, 1'b1,1'b0,5'd0, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd0, 5'd0, 1'b1,1'b1,5'd2, 1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // lw x7 ; load-use consumer coincident with flush ; independent follower
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd0, 1'b1,1'b0,5'd7, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd7, 5'd7, 1'b1,1'b1,5'd8, 1'b1,1'b0,1'b1, 1'b0,2'b00,2'b00,1'b1));
    tbl.push_back(mk(1'b0,1'b1,5'd3, 5'd4, 1'b1,1'b1,5'd11,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // producers x12..x14, reset, then consumers of those registers
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd12,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd13,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd2, 1'b1,1'b1,5'd14,1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b1,1'b0,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    tbl.push_back(mk(1'b0,1'b1,5'd14,5'd13,1'b1,1'b1,5'd15,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd12,5'd14,1'b1,1'b1,5'd16,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // lw x20 ; store-like consumer on rs2 only stalls once then gets MEM/WB
    tbl.push_back(mk(1'b0,1'b1,5'd1, 5'd0, 1'b1,1'b0,5'd20,1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    tbl.push_back(mk(1'b0,1'b1,5'd3, 5'd20,1'b1,1'b1,5'd0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b1));
    tbl.push_back(mk(1'b0,1'b1,5'd3, 5'd20,1'b1,1'b1,5'd0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b10,1'b0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      rv = mk(($urandom_range(49) == 0), ($urandom_range(7) != 0),
              5'($urandom_range(7)), 5'($urandom_range(7)),
              ($urandom_range(5) != 0), ($urandom_range(5) != 0),
              5'($urandom_range(7)), ($urandom_range(4) != 0),
              ($urandom_range(3) == 0), ($urandom_range(9) == 0),
              1'b0, 2'b00, 2'b00, 1'b0);
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
